reg_write_arbiter: RTL and testbench

Round-robin write arbiter sharing one `register` instance (WIDTH-bit, `load`/`rst` controlled) between NREQ requesters. Requesters present data and hold `req` until acknowledged. The arbiter picks one winner, latches its data and drives the register's `load` for exactly one cycle. A separate clear request drives the register's `rst` and takes priority over pending writes.

---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 26 ++
 rtl/reg_write_arbiter.sv | 102 ++++++++++
 tb/tb_reg_write_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM state encoding and a constant-friendly clog2 helper.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after ptr,
// wrapping modulo NREQ, wins.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared register; a clear request
// takes priority over pending writes. Outputs are Moore-decoded from state.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IW    = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  input  logic                  clr,
  output logic [NREQ-1:0]       ack,
  output logic                  clr_ack,
  output logic                  reg_load,
  output logic                  reg_rst,
  output logic [WIDTH-1:0]      reg_data,
  output logic [IW-1:0]         owner,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester raises req (or clr) with stable data and holds it
  // until the one-cycle ack (clr_ack); it drops the request on the next edge,
  // otherwise the still-high request counts as a new one in the next IDLE.

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
    end
  end

  // Clear is only considered in IDLE, so a clr raised during LOAD waits one
  // cycle and still beats any pending req.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
        end else if (pick_valid) begin
          state_d = LOAD;
          owner_d = pick_idx;
          data_d  = data_in[int'(pick_idx)*WIDTH +: WIDTH];
          ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      LOAD:    state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack      = '0;
    reg_load = 1'b0;
    reg_data = '0;
    reg_rst  = 1'b0;
    clr_ack  = 1'b0;
    if (state_q == LOAD) begin
      ack[owner_q] = 1'b1;
      reg_load     = 1'b1;
      reg_data     = data_q;
    end
    if (state_q == CLEAR) begin
      reg_rst = 1'b1;
      clr_ack = 1'b1;
    end
  end

  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural shared register and
// a scoreboard of expected {owner, data} grants.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IW    = 2;
  localparam int W     = IW + WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic                  clr;
  logic [NREQ-1:0]       ack;
  logic                  clr_ack;
  logic                  reg_load;
  logic                  reg_rst;
  logic [WIDTH-1:0]      reg_data;
  logic [IW-1:0]         owner;
  logic                  busy;
  logic [1:0]            dbg_state;

  logic [WIDTH-1:0]      reg_q = '0;
  logic [W-1:0]          exp_q[$];
  int                    n_assert = 0;
  int                    n_fail   = 0;
  int                    lat;

  // clock / reset block
  always #5 clk = ~clk;

  reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .clr       (clr),
    .ack       (ack),
    .clr_ack   (clr_ack),
    .reg_load  (reg_load),
    .reg_rst   (reg_rst),
    .reg_data  (reg_data),
    .owner     (owner),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // shared register model
  always @(posedge clk) begin
    if (reg_rst)       reg_q <= '0;
    else if (reg_load) reg_q <= reg_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  // driver tasks
  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data_in[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_exp(input int i, input logic [WIDTH-1:0] v);
    exp_q.push_back({IW'(i), v});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for an ack, compares against the scoreboard head, drops the
  // granted req and checks the register one edge later.
  task automatic wait_grant(output int latency);
    logic [W-1:0] e;
    int got;
    int idx;
    latency = 0;
    got     = 0;
    while (got == 0 && latency < 20) begin
      @(negedge clk);
      latency++;
      if (ack != '0) got = 1;
    end
    check("grant_seen", got, 1);
    if (got != 0) begin
      e   = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      idx = onehot_idx(ack);
      check("ack_onehot", $countones(ack), 1);
      check("ack_idx", idx, 32'(e[W-1:WIDTH]));
      check("owner", 32'(owner), 32'(e[W-1:WIDTH]));
      check("reg_load", 32'(reg_load), 1);
      check("reg_data", 32'(reg_data), 32'(e[WIDTH-1:0]));
      if (idx >= 0) req[idx] = 1'b0;
      @(negedge clk);
      check("reg_capture", 32'(reg_q), 32'(e[WIDTH-1:0]));
      check("ack_cleared", 32'(ack), 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    clr     = 1'b0;
    data_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_clr_ack", 32'(clr_ack), 0);
    check("rst_reg_load", 32'(reg_load), 0);
    check("rst_reg_rst", 32'(reg_rst), 0);
    check("rst_reg_data", 32'(reg_data), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // single request from requester 2
    set_data(2, 8'hA5);
    push_exp(2, 8'hA5);
    req[2] = 1'b1;
    wait_grant(lat);
    check("single_latency", lat, 1);

    // all four requesters, fresh pointer: grants 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_data(i, 8'h10 + 8'(i));
      push_exp(i, 8'h10 + 8'(i));
    end
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) wait_grant(lat);

    // requesters 0 and 3 re-raise after every ack: strict alternation
    set_data(0, 8'h20);
    set_data(3, 8'h23);
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 8'h20);
      push_exp(3, 8'h23);
    end
    req = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      wait_grant(lat);
      check("alt_latency", lat, 1);
      req = 4'b1001;
    end
    req = '0;

    // preload FF, then clr and req[1] on the same edge: clear wins
    set_data(0, 8'hFF);
    push_exp(0, 8'hFF);
    req[0] = 1'b1;
    wait_grant(lat);
    set_data(1, 8'h77);
    push_exp(1, 8'h77);
    req[1] = 1'b1;
    clr    = 1'b1;
    @(negedge clk);
    check("clr_state", 32'(dbg_state), 2);
    check("clr_ack", 32'(clr_ack), 1);
    check("clr_reg_rst", 32'(reg_rst), 1);
    check("clr_no_load", 32'(reg_load), 0);
    check("clr_no_ack", 32'(ack), 0);
    clr = 1'b0;
    @(negedge clk);
    check("clr_reg_zero", 32'(reg_q), 0);
    check("clr_back_idle", 32'(dbg_state), 0);
    wait_grant(lat);

    // reset during LOAD aborts; pointer returns to 0
    set_data(1, 8'h99);
    req[1] = 1'b1;
    @(negedge clk);
    check("abort_in_load", 32'(dbg_state), 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("abort_ack", 32'(ack), 0);
    check("abort_reg_load", 32'(reg_load), 0);
    check("abort_state", 32'(dbg_state), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_owner", 32'(owner), 0);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'h40 + 8'(i));
    push_exp(0, 8'h40);
    req = 4'b1111;
    wait_grant(lat);
    req = '0;

    // data changed the cycle after the grant edge is ignored
    set_data(1, 8'h3C);
    push_exp(1, 8'h3C);
    req[1] = 1'b1;
    @(posedge clk);
    #1 set_data(1, 8'hC3);
    wait_grant(lat);

    // clr raised during LOAD is serviced from the following IDLE
    set_data(2, 8'h5A);
    push_exp(2, 8'h5A);
    req[2] = 1'b1;
    @(posedge clk);
    #1 clr = 1'b1;
    wait_grant(lat);
    @(negedge clk);
    check("late_clr_state", 32'(dbg_state), 2);
    check("late_clr_ack", 32'(clr_ack), 1);
    clr = 1'b0;
    @(negedge clk);
    check("late_clr_reg_zero", 32'(reg_q), 0);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
